// File: rtl/lights_seq_pkg.sv
// -----------------------------------------------------------------------------
// lights_seq_pkg
// Shared types and constants for the lights sequencer.
//   seq_state_t : sequencer FSM states (IDLE, RUN)
//   CMD_*       : 2-bit move codes understood by the three-lane lights FSM
// -----------------------------------------------------------------------------
package lights_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  localparam logic [1:0] CMD_OUTER = 2'b00;
  localparam logic [1:0] CMD_A     = 2'b01;
  localparam logic [1:0] CMD_B     = 2'b10;
  localparam logic [1:0] CMD_HOLD  = 2'b11;

endpackage

// File: rtl/lights_sequencer_beat_tick.sv
// -----------------------------------------------------------------------------
// beat_tick
// Beat prescaler: counts 0..TICK_DIV-1 while enabled and wraps. `tick` is
// high for the single cycle in which the count sits at its terminal value, so
// a register sampling `tick` updates exactly TICK_DIV edges after a clear.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-low reset
//   clear in  synchronous clear of the count (wins over en)
//   en    in  count enable
//   tick  out one-cycle terminal-count indication
// -----------------------------------------------------------------------------
module beat_tick #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned   CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear, wrap at terminal count, or increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CW{1'b0}};
    end else if (en) begin
      if (cnt_q == TERM) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1'b1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clear && (cnt_q == TERM);

endmodule

// File: rtl/lights_sequencer.sv
// -----------------------------------------------------------------------------
// lights_sequencer
// Beat-driven command sequencer for the three-lane lights FSM. A pattern of
// 2-bit moves is loaded while idle; after start, one move is issued on `w`
// per beat, with the hold code driven on all other cycles.
// Ports:
//   clk       in  system clock
//   reset     in  asynchronous active-low reset
//   start     in  begin playback (IDLE only)
//   stop      in  abort playback; beats a coincident beat and start
//   len       in  index of last step, latched on accepted start
//   load_en   in  pattern slot write enable (IDLE only)
//   load_addr in  pattern slot to write
//   load_data in  move code to write
//   w         out command to lights FSM (hold 2'b11 except on beats)
//   step      out one-cycle pulse on every beat
//   step_idx  out slot index issued on the current/last beat
//   busy      out playback active (lags the FSM by one cycle)
//   done      out pulse on the final beat of a completed sequence
// Build option: define LIGHTS_SEQ_LOOP_EN to loop the pattern forever instead
// of finishing after the last step.
// -----------------------------------------------------------------------------
module lights_sequencer
  import lights_seq_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [$clog2(DEPTH)-1:0] len,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [1:0]               load_data,
  output logic [1:0]               w,
  output logic                     step,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] last_q, last_d;
  logic [1:0]    pat_q [DEPTH];
  logic [1:0]    w_q, w_d;
  logic          step_q, step_d;
  logic [AW-1:0] step_idx_q, step_idx_d;
  logic          busy_q;
  logic          done_q, done_d;

  logic          tick_s;
  logic          clear_s;
  logic          run_s;

  // Prescaler is held at zero throughout IDLE, so it starts from zero on the
  // edge that accepts start.
  assign clear_s = (state_q == IDLE);
  assign run_s   = (state_q == RUN);

  beat_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_beat_tick (
    .clk   (clk),
    .reset (reset),
    .clear (clear_s),
    .en    (run_s),
    .tick  (tick_s)
  );

  // FSM next state, step index and next output values.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    w_d        = CMD_HOLD;
    step_d     = 1'b0;
    step_idx_d = step_idx_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          last_d  = len;
          idx_d   = {AW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          // Abort wins over a coincident beat: outputs stay at hold.
          state_d = IDLE;
        end else if (tick_s) begin
          w_d        = pat_q[idx_q];
          step_d     = 1'b1;
          step_idx_d = idx_q;
          if (idx_q == last_q) begin
`ifdef LIGHTS_SEQ_LOOP_EN
            idx_d   = {AW{1'b0}};
            state_d = RUN;
`else
            done_d  = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            idx_d = idx_q + AW'(1'b1);
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pattern storage; writable only while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pat_q[i] <= CMD_HOLD;
      end
    end else if (load_en && (state_q == IDLE)) begin
      pat_q[load_addr] <= load_data;
    end
  end

  // FSM, index and output registers. busy follows the state one cycle late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= {AW{1'b0}};
      last_q     <= {AW{1'b0}};
      w_q        <= CMD_HOLD;
      step_q     <= 1'b0;
      step_idx_q <= {AW{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      w_q        <= w_d;
      step_q     <= step_d;
      step_idx_q <= step_idx_d;
      busy_q     <= (state_q == RUN);
      done_q     <= done_d;
    end
  end

  assign w        = w_q;
  assign step     = step_q;
  assign step_idx = step_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lights_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lights_sequencer
// Self-checking bench for lights_sequencer with TICK_DIV=4, DEPTH=16.
// Expected outputs come from a timeline model: for a run accepted at edge k,
// the state after edge k+r is derived directly from r, the beat period, the
// step count and the stop edge. Honours LIGHTS_SEQ_LOOP_EN if defined.
// -----------------------------------------------------------------------------
module tb_lights_sequencer;

  localparam int T  = 4;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int NEVER = 1 << 30;
`ifdef LIGHTS_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic [AW-1:0] len;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [1:0]    load_data;
  logic [1:0]    w;
  logic          step;
  logic [AW-1:0] step_idx;
  logic          busy;
  logic          done;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] mdl_pat [D];
  int         mdl_sidx;

  lights_sequencer #(
    .DEPTH    (D),
    .TICK_DIV (T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .len       (len),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .w         (w),
    .step      (step),
    .step_idx  (step_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) mdl_pat[i] = 2'b11;
    mdl_sidx = 0;
  endtask

  task automatic do_load(input int a, input logic [1:0] d);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    mdl_pat[a] = d;
    check_eq("busy_load", {31'd0, busy}, 32'd0);
  endtask

  // Inputs for edge k+rn. gmode: 0 quiet, 1 random junk, 2 slot1<=00 + start.
  task automatic drive_run(input int rn, input int stop_eff, input int end_r, input int gmode);
    stop    = (rn == stop_eff);
    start   = 1'b0;
    load_en = 1'b0;
    if (rn <= end_r && gmode == 1) begin
      start     = 1'($urandom_range(0, 1));
      load_en   = 1'($urandom_range(0, 1));
      load_addr = AW'($urandom_range(0, D - 1));
      load_data = 2'($urandom_range(0, 3));
    end else if (rn <= end_r && gmode == 2) begin
      start     = 1'(rn % 2);
      load_en   = 1'b1;
      load_addr = AW'(1);
      load_data = 2'b00;
    end
  endtask

  // Start a run with last index len_v, optional stop at edge k+stop_at.
  task automatic run_seq(input int len_v, input int stop_at, input int gmode);
    int nb, nat_end, stop_eff, end_r, n, sa;
    bit beat;
    logic [1:0] ew;
    nb = len_v + 1;
    sa = stop_at;
    if (LOOP) begin
      if (sa < 1) sa = 2 * nb * T + $urandom_range(0, T);
      nat_end = sa;
    end else begin
      nat_end = nb * T;
    end
    stop_eff = (sa >= 1 && sa <= nat_end) ? sa : NEVER;
    end_r    = (stop_eff <= nat_end) ? stop_eff : nat_end;
    len   = AW'(len_v);
    start = 1'b1;
    stop  = 1'b0;
    @(posedge clk); #1;
    drive_run(1, stop_eff, end_r, gmode);
    for (int r = 1; r <= end_r + 2; r++) begin
      @(posedge clk); #1;
      n    = r / T;
      beat = (r % T == 0) && (n >= 1) && (r < stop_eff) && (LOOP || n <= nb);
      ew   = 2'b11;
      if (beat) begin
        mdl_sidx = (n - 1) % nb;
        ew       = mdl_pat[mdl_sidx];
      end
      check_eq($sformatf("w r=%0d", r),    {30'd0, w},    {30'd0, ew});
      check_eq($sformatf("step r=%0d", r), {31'd0, step}, {31'd0, beat});
      check_eq($sformatf("sidx r=%0d", r), {28'd0, step_idx}, 32'(mdl_sidx));
      check_eq($sformatf("busy r=%0d", r), {31'd0, busy}, {31'd0, (r <= end_r)});
      check_eq($sformatf("done r=%0d", r), {31'd0, done},
               {31'd0, (beat && !LOOP && n == nb)});
      drive_run(r + 1, stop_eff, end_r, gmode);
    end
  endtask

  initial begin
    int nl, lv, sa;
    reset = 1'b0; start = 1'b0; stop = 1'b0; len = '0;
    load_en = 1'b0; load_addr = '0; load_data = 2'b00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_w",    {30'd0, w},        32'd3);
    check_eq("rst_step", {31'd0, step},     32'd0);
    check_eq("rst_busy", {31'd0, busy},     32'd0);
    check_eq("rst_done", {31'd0, done},     32'd0);
    check_eq("rst_sidx", {28'd0, step_idx}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic playback with ignored loads/starts during the run, then replay.
    do_load(0, 2'b01);
    do_load(1, 2'b10);
    do_load(2, 2'b00);
    run_seq(2, -1, 2);
    run_seq(2, -1, 0);
    // Stop at k+6: the beat at k+8 never appears.
    run_seq(2, 6, 0);
    // Stop exactly on a beat edge suppresses it.
    run_seq(3, 8, 0);

    // start together with stop in IDLE is not accepted.
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    @(posedge clk); #1;
    check_eq("startstop_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check_eq("startstop_busy2", {31'd0, busy}, 32'd0);
    check_eq("startstop_w",     {30'd0, w},    32'd3);

    // Randomized runs with random pattern edits and junk inputs during RUN.
    for (int it = 0; it < 20; it++) begin
      nl = $urandom_range(0, 4);
      for (int j = 0; j < nl; j++) do_load($urandom_range(0, D - 1), 2'($urandom_range(0, 3)));
      lv = (it % 4 == 0) ? D - 1 : $urandom_range(0, 5);
      sa = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (lv + 1) * T + 2) : -1;
      run_seq(lv, sa, 1);
    end

    // Asynchronous reset between edges mid-run.
    len = AW'(15); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_eq("arst_busy", {31'd0, busy},     32'd0);
    check_eq("arst_w",    {30'd0, w},        32'd3);
    check_eq("arst_step", {31'd0, step},     32'd0);
    check_eq("arst_done", {31'd0, done},     32'd0);
    check_eq("arst_sidx", {28'd0, step_idx}, 32'd0);
    @(posedge clk); #1;
    check_eq("arst_hold_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    run_seq(15, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
